uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Parametrised UART transmitter: serialises one DATA_BITS-wide word per frame (start bit, data LSB first, optional parity, 1 or 2 stop bits) at CLKS_PER_BIT clocks per bit.
- Takes words over a valid/ready handshake, so it can be fed back-to-back from a FIFO or a register-file master.
- Sits between the host-side protocol logic and the FPGA tx pin.
- Intended successor to the fixed 8-bit, one-clock-per-bit transmitter.

Parameters:
- DATA_BITS, 8, data word width; legal range 5..9.
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); must be >= 2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous reset, active low.
- data  in  DATA_BITS  word to transmit; sampled only on acceptance.
- valid  in  1  data holds a word to send.
- ready  out  1  block can accept a word this cycle.
- tx  out  1  serial line; idles high.
- busy  out  1  frame in progress (any state but IDLE).
- done  out  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, tx=1, busy=0, done=0, bit and baud counters=0.
  - ready=1 as soon as rst_n deasserts.
  - Reset mid-frame abandons the frame: tx goes to 1 immediately and no done pulse is issued.
- Acceptance happens when valid && ready on a rising edge.
  - ready is high only in IDLE; valid is ignored elsewhere.
  - data is captured into a shift register; later changes on data have no effect.
  - The parity bit is computed from the captured word: even = XOR of the bits, odd = inverted XOR.
- FSM states and transitions:
  - IDLE: tx=1, ready=1. On acceptance, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift register bit 0 for CLKS_PER_BIT cycles; then shift right and increment the bit counter.
    - After DATA_BITS bits, go to PARITY if PARITY != 0, else to STOP.
  - PARITY: tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE with done=1 in that first IDLE cycle.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Cleared on acceptance and on every bit boundary.
  - Bit-end strobe fires when the count reaches CLKS_PER_BIT-1.
- Latency: tx falls in the cycle immediately after the accepting edge.
- Frame length: F = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
  - done is asserted F+1 cycles after the accepting edge.
- Back-to-back transfer: if valid is high in the IDLE cycle where done=1, that word is accepted in the same cycle.
  - Frame-to-frame period is F+1 cycles, including exactly one idle-high cycle.
- tx, done and busy are registered outputs; ready is decoded from state.
- There is no glitch on tx at bit boundaries.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined: adds input port brk (1 bit).
  - brk=1 while in IDLE forces tx=0 and ready=0 for as long as brk is held.
  - brk asserted mid-frame is deferred until the frame completes, after done is issued.
  - Releasing brk returns tx=1 on the next cycle; ready is 1 again in the cycle after that.
- Undefined: no brk port; IDLE behaviour is as above.

Decomposition:
- Package uart_pkg holds:
  - PARITY_NONE/PARITY_EVEN/PARITY_ODD constants;
  - the tx FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - a clog2-based counter-width helper constant.
- Sub-module uart_baud_tick: parametrised by CLKS_PER_BIT; inputs clk, rst_n, restart; output bit_end strobe.
  - The receiver will reuse it later.

Test Plan:
- DATA_BITS=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; send 0xA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; done pulses 41 cycles after acceptance.
- PARITY=1, send 0x07 -> parity bit 1; PARITY=2, send 0x07 -> parity bit 0; frame = 44 cycles at CLKS_PER_BIT=4.
- valid held high with 0x55 then 0xAA -> second acceptance in the done cycle; start bits exactly 41 cycles apart; exactly one idle-high cycle between frames.
- STOP_BITS=2 -> tx high for 8 cycles after the last data bit; done at cycle 45.
- Pulse rst_n low during data bit 3 -> tx=1 immediately, busy=0, no done; after release, 0x3C transmits correctly.
- UART_TX_BREAK_EN: assert brk mid-frame -> frame finishes with done, then tx=0 and ready=0 until brk drops; tx=1 next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and the baud tick generator.
//   - PARITY_NONE / PARITY_EVEN / PARITY_ODD : values for the PARITY parameter
//   - tx_state_t                             : transmitter FSM encoding
//   - cnt_w()                                : counter width for a modulus
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Width of a counter that has to hold 0..n-1; never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Counts clock cycles within one serial bit and flags the last cycle of it.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous reset, active low
//   restart  in   clear the count (frame start and every bit boundary)
//   bit_end  out  high in the last cycle of a bit (count == CLKS_PER_BIT-1)
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_end
);

    localparam int              CW   = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bit_end = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits, each CLKS_PER_BIT clocks long. Words arrive over a
// valid/ready handshake; a word offered in the done cycle is accepted at once,
// so back-to-back frames are separated by exactly one idle-high cycle.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous reset, active low (abandons any frame)
//   data   in   word to send, captured on acceptance
//   valid  in   data holds a word
//   ready  out  word can be accepted this cycle (IDLE only)
//   tx     out  serial line, registered, idles high
//   busy   out  frame in progress, registered
//   done   out  one-cycle pulse after the last stop bit, registered
//   brk    in   (UART_TX_BREAK_EN only) hold line low while idle
// Build option: define UART_TX_BREAK_EN to add the brk port.
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
`ifdef UART_TX_BREAK_EN
    input  logic                 brk,
`endif
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int             BCW       = cnt_w(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    tx_state_t              state_q, state_nxt;
    logic [DATA_BITS-1:0]   shreg_q, shreg_nxt;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_nxt;
    logic                   par_q, par_nxt;
    logic                   tx_nxt, busy_nxt, done_nxt;
    logic                   accept, bit_end, brk_in, brk_block;

`ifdef UART_TX_BREAK_EN
    // brk_act_q: line is being held low; brk_hold_q delays ready by one more
    // cycle after release so the line is high for a cycle before a new frame.
    logic brk_act_q, brk_hold_q;

    assign brk_in    = brk;
    assign brk_block = brk | brk_act_q | brk_hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_act_q  <= 1'b0;
            brk_hold_q <= 1'b0;
        end else begin
            brk_act_q  <= (state_q == ST_IDLE) && brk;
            brk_hold_q <= brk_act_q;
        end
    end
`else
    assign brk_in    = 1'b0;
    assign brk_block = 1'b0;
`endif

    assign ready  = (state_q == ST_IDLE) && !brk_block;
    assign accept = valid && ready;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (accept | bit_end),
        .bit_end (bit_end)
    );

    always_comb begin
        state_nxt   = state_q;
        shreg_nxt   = shreg_q;
        bit_cnt_nxt = bit_cnt_q;
        par_nxt     = par_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt   = ST_START;
                    shreg_nxt   = data;
                    bit_cnt_nxt = '0;
                    par_nxt     = (^data) ^ (PARITY == PARITY_ODD);
                end
            end
            ST_START: begin
                if (bit_end) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_nxt = shreg_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt_q + BCW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = ST_IDLE;
                    end else begin
                        bit_cnt_nxt = bit_cnt_q + BCW'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Line level is decoded from the next state so tx changes exactly on
        // the bit boundary edge without any combinational path to the pin.
        // Break only applies from a settled IDLE, so the done cycle stays high.
        case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = shreg_nxt[0];
            ST_PARITY: tx_nxt = par_q;
            ST_STOP:   tx_nxt = 1'b1;
            default:   tx_nxt = !((state_q == ST_IDLE) && brk_in);
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state_q == ST_STOP) && (state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            shreg_q   <= shreg_nxt;
            bit_cnt_q <= bit_cnt_nxt;
            par_q     <= par_nxt;
            tx        <= tx_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
// Four transmitters at CLKS_PER_BIT=4, DATA_BITS=8:
//   0: no parity, 1 stop   1: even parity   2: odd parity   3: 2 stop bits
// Expected line/handshake activity is built per cycle from the frame format.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data [4];
    logic [3:0] valid, ready, tx, busy, done;
`ifdef UART_TX_BREAK_EN
    logic       brk;
`endif

    int checks = 0;
    int errors = 0;

    // Per-cycle expectation: {tx, done, busy, ready}
    logic [3:0] exp_v[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_frame #(
            .DATA_BITS    (8),
            .CLKS_PER_BIT (C),
            .PARITY       ((g == 1) ? 1 : (g == 2) ? 2 : 0),
            .STOP_BITS    ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .data  (data[g]),
            .valid (valid[g]),
`ifdef UART_TX_BREAK_EN
            .brk   (brk),
`endif
            .ready (ready[g]),
            .tx    (tx[g]),
            .busy  (busy[g]),
            .done  (done[g])
        );
    end

    function automatic int par_of(int i);
        return (i == 1) ? 1 : (i == 2) ? 2 : 0;
    endfunction

    function automatic int stb_of(int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int flen(int i);
        return (9 + ((par_of(i) != 0) ? 1 : 0) + stb_of(i)) * C;
    endfunction

    // Append one frame plus its done cycle to exp_v.
    task automatic push_frame(int i, logic [7:0] w);
        logic bits[$];
        bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) bits.push_back(w[b]);
        if (par_of(i) == 1) bits.push_back(^w);
        if (par_of(i) == 2) bits.push_back(~^w);
        for (int s = 0; s < stb_of(i); s++) bits.push_back(1'b1);
        foreach (bits[j])
            repeat (C) exp_v.push_back({bits[j], 3'b010});
        exp_v.push_back(4'b1101);
    endtask

    // Offer w0 (and w1 back-to-back if two) and compare every cycle.
    task automatic run_check(int i, string name, logic [7:0] w0, logic [7:0] w1, bit two);
        exp_v.delete();
        push_frame(i, w0);
        if (two) push_frame(i, w1);
        exp_v.push_back(4'b1001);
        @(negedge clk);
        data[i]  = w0;
        valid[i] = 1'b1;
        checks++;
        if (ready[i] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept: got %b expected 1", name, ready[i]);
        end
        for (int k = 0; k < exp_v.size(); k++) begin
            @(negedge clk);
            if (k == 0) begin
                data[i]  = two ? w1 : 8'($urandom);
                valid[i] = two;
            end
            if (k == flen(i) + 1) begin
                valid[i] = 1'b0;
                data[i]  = 8'($urandom);
            end
            checks++;
            if ({tx[i], done[i], busy[i], ready[i]} !== exp_v[k]) begin
                errors++;
                $display("FAIL %s cycle %0d: {tx,done,busy,ready} got %b expected %b",
                         name, k, {tx[i], done[i], busy[i], ready[i]}, exp_v[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = '0;
        for (int i = 0; i < 4; i++) data[i] = '0;
`ifdef UART_TX_BREAK_EN
        brk = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if ({tx, busy, done} !== {4'hF, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_outputs: {tx,busy,done} got %b expected %b",
                     {tx, busy, done}, {4'hF, 4'h0, 4'h0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready, tx} !== 8'hFF) begin
            errors++;
            $display("FAIL reset_release: {ready,tx} got %b expected 11111111", {ready, tx});
        end
    endtask

    task automatic test_frame();
        run_check(0, "frame_a5", 8'hA5, 8'h00, 1'b0);
        repeat (3) run_check(0, "frame_rand", 8'($urandom), 8'h00, 1'b0);
    endtask

    task automatic test_parity();
        run_check(1, "even_07", 8'h07, 8'h00, 1'b0);
        run_check(2, "odd_07", 8'h07, 8'h00, 1'b0);
        repeat (2) begin
            run_check(1, "even_rand", 8'($urandom), 8'h00, 1'b0);
            run_check(2, "odd_rand", 8'($urandom), 8'h00, 1'b0);
        end
    endtask

    task automatic test_stop2();
        run_check(3, "stop2_rand", 8'($urandom), 8'h00, 1'b0);
        run_check(3, "stop2_rand", 8'($urandom), 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_check(0, "b2b_55_aa", 8'h55, 8'hAA, 1'b1);
        run_check(1, "b2b_rand", 8'($urandom), 8'($urandom), 1'b1);
        run_check(3, "b2b_rand", 8'($urandom), 8'($urandom), 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        w = 8'($urandom);
        @(negedge clk);
        data[0]  = w;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        checks++;
        if (tx[0] !== w[3]) begin
            errors++;
            $display("FAIL mid_data_bit3: tx got %b expected %b", tx[0], w[3]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx[0], busy[0], done[0]} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset_async: {tx,busy,done} got %b expected 100",
                     {tx[0], busy[0], done[0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            checks++;
            if ({tx[0], done[0]} !== 2'b10) begin
                errors++;
                $display("FAIL mid_reset_quiet cycle %0d: {tx,done} got %b expected 10",
                         k, {tx[0], done[0]});
            end
        end
        run_check(0, "after_reset_3c", 8'h3C, 8'h00, 1'b0);
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        logic [7:0] w;
        int f;
        w = 8'($urandom);
        f = flen(0);
        exp_v.delete();
        push_frame(0, w);
        exp_v[f] = 4'b1100;
        repeat (5) exp_v.push_back(4'b0000);
        exp_v.push_back(4'b1000);
        exp_v.push_back(4'b1001);
        @(negedge clk);
        data[0]  = w;
        valid[0] = 1'b1;
        for (int k = 0; k < exp_v.size(); k++) begin
            @(negedge clk);
            if (k == 0) valid[0] = 1'b0;
            checks++;
            if ({tx[0], done[0], busy[0], ready[0]} !== exp_v[k]) begin
                errors++;
                $display("FAIL break cycle %0d: {tx,done,busy,ready} got %b expected %b",
                         k, {tx[0], done[0], busy[0], ready[0]}, exp_v[k]);
            end
            if (k == 10) brk = 1'b1;
            if (k == f + 5) brk = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
